// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues instruction-memory requests and hands
// each accepted instruction, tagged with its PC, to decode.
module pc_fetch_ctrl #(
  parameter int unsigned              ADDR_W    = 32,
  parameter int unsigned              DATA_W    = 32,
  parameter logic        [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic        [ADDR_W-1:0] INC       = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              halt,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [31:0]       fetch_count,
  output logic              halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic [31:0]         fetch_count_q, fetch_count_d;
  logic                halted_q, halted_d;
  logic                accept;

  // Request only depends on state and stall; halt/redirect merely veto acceptance.
  assign imem_req = (state_q == RUN) && !stall;
  assign accept   = imem_req && imem_ack && !redirect_valid && !halt;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = 1'b0;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (accept) begin
          instr_valid_d = 1'b1;
          instr_d       = imem_rdata;
          instr_pc_d    = pc_q;
          pc_d          = pc_q + INC;
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = BOOT;
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VEC;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_count_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
      halted_q      <= halted_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = fetch_count_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset, streaming, slow memory, redirect,
// stall, PC wrap and halt, each checked against hand-computed values.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] fetch_count;
  logic        halted;

  int errors = 0;
  int checks = 0;

  pc_fetch_ctrl #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_VEC(32'd0),
    .INC      (32'd1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt           (halt),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_count    (fetch_count),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs then change 1ns later, away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    halt = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    cyc();
    cyc();
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    rst = 1'b0;
    #1;
    chk("boot_req", {31'd0, imem_req}, 32'd0);
    chk("boot_pc", pc_out, 32'd0);
    cyc();
    chk("run_req", {31'd0, imem_req}, 32'd1);
    chk("run_addr", imem_addr, 32'd0);

    // Streaming: ack every cycle, rdata = 0xA0 + addr
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata = 32'hA0 + i;
      #1;
      chk("stream_addr", imem_addr, i);
      cyc();
      chk("stream_valid", {31'd0, instr_valid}, 32'd1);
      chk("stream_pc", instr_pc, i);
      chk("stream_instr", instr, 32'hA0 + i);
    end
    chk("stream_count", fetch_count, 32'd4);
    imem_rdata = 32'hA4;
    cyc();
    chk("pre_slow_pc", pc_out, 32'd5);

    // Slow memory: ack low for 3 cycles at address 5
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("slow_addr", imem_addr, 32'd5);
      chk("slow_req", {31'd0, imem_req}, 32'd1);
      cyc();
      chk("slow_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1; imem_rdata = 32'h55;
    #1;
    chk("slow_addr4", imem_addr, 32'd5);
    cyc();
    chk("slow_valid_ack", {31'd0, instr_valid}, 32'd1);
    chk("slow_ipc", instr_pc, 32'd5);
    chk("slow_instr", instr, 32'h55);
    chk("slow_pc_next", pc_out, 32'd6);
    chk("slow_count", fetch_count, 32'd6);

    // Redirect vs ack at pc=7
    imem_rdata = 32'h66;
    cyc();
    chk("pre_redir_pc", pc_out, 32'd7);
    redirect_valid = 1'b1; redirect_target = 32'h40; imem_rdata = 32'h77;
    cyc();
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_count", fetch_count, 32'd7);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_instr_hold", instr, 32'h66);
    chk("redir_ipc_hold", instr_pc, 32'd6);

    // Stall with ack for 2 cycles
    redirect_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      cyc();
      chk("stall_pc", pc_out, 32'h40);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
      chk("stall_count", fetch_count, 32'd7);
    end
    stall = 1'b0;
    #1;
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h40);
    cyc();
    chk("resume_valid", {31'd0, instr_valid}, 32'd1);
    chk("resume_ipc", instr_pc, 32'h40);
    chk("resume_pc", pc_out, 32'h41);
    chk("resume_count", fetch_count, 32'd8);

    // Wrap: redirect to all-ones, then accept there
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    cyc();
    chk("wrap_preload", pc_out, 32'hFFFF_FFFF);
    redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD;
    cyc();
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFF);
    chk("wrap_instr", instr, 32'hDEAD);
    chk("wrap_pc", pc_out, 32'd0);
    chk("wrap_count", fetch_count, 32'd9);

    // Halt together with redirect and ack
    halt = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h123;
    cyc();
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    chk("halt_pc", pc_out, 32'd0);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_count", fetch_count, 32'd9);
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("halted_stay", {31'd0, halted}, 32'd1);
      chk("halted_pc", pc_out, 32'd0);
      chk("halted_req", {31'd0, imem_req}, 32'd0);
      chk("halted_valid", {31'd0, instr_valid}, 32'd0);
    end

    // Reset leaves HALTED
    rst = 1'b1; redirect_valid = 1'b0; imem_ack = 1'b0;
    cyc();
    chk("rst2_halted", {31'd0, halted}, 32'd0);
    chk("rst2_count", fetch_count, 32'd0);
    chk("rst2_ipc", instr_pc, 32'd0);
    rst = 1'b0;
    cyc();
    chk("rst2_req", {31'd0, imem_req}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Fetch sequencer that owns the program counter register and drives instruction-memory requests. It selects the next PC from four sources: reset vector, sequential increment, redirect target (branch/jump) and hold (stall). It hands each fetched instruction, tagged with its PC, to decode. It sits between the PC adder path and the instruction memory, at the front of the datapath.

Parameters:
ADDR_W, 32, width of the PC and the instruction-memory address.
DATA_W, 32, instruction width.
RESET_VEC, 0, PC value loaded on reset.
INC, 1, sequential PC increment (word addressing).

Ports:
clk  in  1  system clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  decode backpressure; blocks request issue and instruction acceptance.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_target  in  ADDR_W  new PC when redirect_valid=1.
halt  in  1  stop fetching until the next reset.
imem_ack  in  1  imem_rdata is valid for the imem_addr presented this cycle.
imem_rdata  in  DATA_W  instruction word from memory.
imem_req  out  1  fetch request; combinational.
imem_addr  out  ADDR_W  fetch address; always equals pc_out.
pc_out  out  ADDR_W  current PC register.
instr_valid  out  1  registered; instr/instr_pc are valid this cycle.
instr  out  DATA_W  registered fetched instruction.
instr_pc  out  ADDR_W  PC of instr.
fetch_count  out  32  number of accepted instructions; wraps modulo 2^32.
halted  out  1  high while in the HALTED state.

Behaviour:
- Reset is synchronous, active-high and wins over everything, including mid-request.
  - Reset values: state=BOOT, pc_out=RESET_VEC, instr_valid=0, instr=0, instr_pc=0, fetch_count=0, halted=0.
- States:
  - BOOT: imem_req=0. Goes to RUN on the next cycle, so the first request appears 1 cycle after rst deasserts.
  - RUN: imem_req = !stall.
  - HALTED: imem_req=0, halted=1. The block stays here until rst.
- Accept condition (RUN only): imem_req && imem_ack && !redirect_valid && !halt.
  - On accept, next edge: instr<=imem_rdata, instr_pc<=pc_out, instr_valid<=1, pc_out<=pc_out+INC, fetch_count+=1.
  - Without accept, instr_valid<=0 and instr/instr_pc hold their values.
  - Fetch latency: 1 cycle from ack to instr_valid.
- Request hold: while imem_req=1 and imem_ack=0, imem_addr stays stable. A multi-cycle ack delay causes no PC change.
- Stall: imem_req=0, an ack that cycle is ignored, pc_out holds, instr_valid<=0.
- Redirect (RUN): pc_out<=redirect_target next edge.
  - Takes priority over stall and ack. An ack in the same cycle is discarded: no instr_valid, no fetch_count change.
  - The next request uses the target address.
- Halt (RUN): go to HALTED next edge.
  - Takes priority over redirect and ack. pc_out holds, instr_valid<=0.
- Priority, high to low: rst > halt > redirect_valid > stall > ack.
- Inputs in BOOT and HALTED: redirect_valid, stall and imem_ack are ignored.
- Arithmetic: pc_out+INC is truncated to ADDR_W bits, so 2^ADDR_W-1 + 1 wraps to 0. fetch_count wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset: assert rst for 2 cycles, then release. Required: pc_out=0, imem_req=0 in the first cycle after release; imem_req=1 with imem_addr=0 in the second cycle.
- Streaming: ack=1 every cycle, rdata=0xA0+addr. Required: instr_valid from the cycle after the first ack; instr_pc 0,1,2,3; instr 0xA0..0xA3; fetch_count=4.
- Slow memory: ack low 3 cycles, then high. Required: imem_addr held at 5 for 4 cycles; one instr_valid pulse with instr_pc=5; pc_out then becomes 6.
- Redirect vs ack: at pc=7, redirect_valid=1, target=0x40, ack=1 in the same cycle. Required: no instr_valid, fetch_count unchanged, next imem_addr=0x40.
- Stall with ack: stall=1 for 2 cycles with ack=1. Required: imem_req=0, pc_out unchanged, instr_valid=0; fetching resumes at the same address when stall drops.
- Wrap and halt: preload pc via redirect to 0xFFFFFFFF, then ack. Required: instr_pc=0xFFFFFFFF, pc_out=0. Then assert halt together with redirect. Required: halted=1, imem_req=0, pc_out stays 0 until rst.
